// File: rtl/round_sequencer.sv
// round_sequencer: sequences one morse-game round (player1 entry, lock, player2 guessing, verdict) and keeps the score.
// Define ROUND_SEQ_TIMEOUT_EN to enable the guess-phase timer; otherwise timer_o is tied 0 and GUESS never times out.
module round_sequencer #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int TIME_LIMIT   = 50000000,
  parameter int TIMER_W      = 26,
  parameter int SCORE_W      = 4
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               p1_done_i,
  input  logic [9:0]         p1_value_i,
  input  logic               p2_done_i,
  input  logic               p2_complete_i,
  output logic               p1_en_o,
  output logic               p2_en_o,
  output logic               p2_clear_o,
  output logic [9:0]         locked_code_o,
  output logic [3:0]         attempts_left_o,
  output logic [TIMER_W-1:0] timer_o,
  output logic               win_o,
  output logic               lose_o,
  output logic [SCORE_W-1:0] score_o
);
  typedef enum logic [2:0] {IDLE, P1_ENTRY, LOCK, GUESS, CLEAR, WIN, LOSE} state_t;
  localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);
  state_t state_q, state_d;
  logic [9:0] code_q, code_d;
  logic [3:0] att_q, att_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic p1_en_q, p2_en_q, p2_clear_q, win_q, lose_q;
  logic expired;
`ifdef ROUND_SEQ_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIME_LIMIT);
  logic [TIMER_W-1:0] timer_q, timer_d;
  assign expired = timer_q == '0;
  assign timer_o = timer_q;
  // Reload only in LOCK so the CLEAR gap between guesses keeps the remaining budget.
  always_comb begin
    timer_d = timer_q;
    if (!abort_i && state_q == LOCK) timer_d = LIMIT;
    else if (!abort_i && state_q == GUESS && !expired) timer_d = timer_q - TIMER_W'(1);
  end
  always_ff @(posedge clock_i or negedge resetn_i)
    if (!resetn_i) timer_q <= '0;
    else timer_q <= timer_d;
`else
  assign expired = 1'b0;
  assign timer_o = '0;
`endif
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    att_d   = att_q;
    score_d = score_q;
    if (abort_i) state_d = IDLE;
    else case (state_q)
      IDLE:     if (start_i) state_d = P1_ENTRY;
      P1_ENTRY: if (p1_done_i && p1_value_i != '0) begin
        state_d = LOCK;
        code_d  = p1_value_i;
      end
      LOCK: begin
        att_d   = MAX_A;
        state_d = GUESS;
      end
      GUESS: if (p2_complete_i) begin
        state_d = WIN;
        score_d = &score_q ? score_q : score_q + SCORE_W'(1);
      end else if (p2_done_i) begin
        att_d   = att_q - 4'd1;
        state_d = (att_q == 4'd1) ? LOSE : CLEAR;
      end else if (expired) state_d = LOSE;
      CLEAR:     state_d = GUESS;
      WIN, LOSE: if (start_i) state_d = P1_ENTRY;
      default:   state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock_i or negedge resetn_i)
    if (!resetn_i) begin
      state_q    <= IDLE;
      code_q     <= '0;
      att_q      <= MAX_A;
      score_q    <= '0;
      p1_en_q    <= 1'b0;
      p2_en_q    <= 1'b0;
      p2_clear_q <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      att_q      <= att_d;
      score_q    <= score_d;
      p1_en_q    <= state_d == P1_ENTRY;
      p2_en_q    <= state_d == GUESS;
      p2_clear_q <= state_d == LOCK || state_d == CLEAR;
      win_q      <= state_d == WIN;
      lose_q     <= state_d == LOSE;
    end
  assign p1_en_o         = p1_en_q;
  assign p2_en_o         = p2_en_q;
  assign p2_clear_o      = p2_clear_q;
  assign locked_code_o   = code_q;
  assign attempts_left_o = att_q;
  assign win_o           = win_q;
  assign lose_o          = lose_q;
  assign score_o         = score_q;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed and random rounds checked every cycle against a phase-level reference model.
module tb_round_sequencer;
  localparam int MAXA = 3, TL = 8, TW = 5, SW = 4;
`ifdef ROUND_SEQ_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic start = 1'b0, abort = 1'b0, p1_done = 1'b0, p2_done = 1'b0, p2_complete = 1'b0;
  logic [9:0] p1_value = '0;
  logic p1_en, p2_en, p2_clear, win, lose;
  logic [9:0] locked;
  logic [3:0] att;
  logic [TW-1:0] timer;
  logic [SW-1:0] score;
  int vectors = 0, miscompares = 0, clears = 0;
  string ph;
  int m_code, m_att, m_tmr, m_score;

  round_sequencer #(.MAX_ATTEMPTS(MAXA), .TIME_LIMIT(TL), .TIMER_W(TW), .SCORE_W(SW)) dut (
    .clock_i(clk), .resetn_i(rstn), .start_i(start), .abort_i(abort),
    .p1_done_i(p1_done), .p1_value_i(p1_value), .p2_done_i(p2_done), .p2_complete_i(p2_complete),
    .p1_en_o(p1_en), .p2_en_o(p2_en), .p2_clear_o(p2_clear), .locked_code_o(locked),
    .attempts_left_o(att), .timer_o(timer), .win_o(win), .lose_o(lose), .score_o(score)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = "idle"; m_code = 0; m_att = MAXA; m_tmr = 0; m_score = 0;
  endtask

  // One clock of the round rules, applied to the inputs held across the edge.
  task automatic model_step();
    string n;
    bit out;
    n = ph;
    out = TO && m_tmr == 0;
    if (abort) n = "idle";
    else if (ph == "idle") begin
      if (start) n = "p1";
    end else if (ph == "p1") begin
      if (p1_done && p1_value != 0) begin n = "lock"; m_code = int'(p1_value); end
    end else if (ph == "lock") begin
      n = "guess"; m_att = MAXA; m_tmr = TO ? TL : 0;
    end else if (ph == "guess") begin
      if (TO && m_tmr > 0) m_tmr--;
      if (p2_complete) begin n = "win"; if (m_score < 2**SW - 1) m_score++; end
      else if (p2_done) begin m_att--; n = (m_att == 0) ? "lose" : "clear"; end
      else if (out) n = "lose";
    end else if (ph == "clear") n = "guess";
    else if (start) n = "p1";
    ph = n;
  endtask

  task automatic check_all();
    chk("p1_en", 32'(p1_en), 32'(ph == "p1"));
    chk("p2_en", 32'(p2_en), 32'(ph == "guess"));
    chk("p2_clear", 32'(p2_clear), 32'(ph == "lock" || ph == "clear"));
    chk("win", 32'(win), 32'(ph == "win"));
    chk("lose", 32'(lose), 32'(ph == "lose"));
    chk("locked_code", 32'(locked), 32'(m_code));
    chk("attempts_left", 32'(att), 32'(m_att));
    chk("timer", 32'(timer), 32'(m_tmr));
    chk("score", 32'(score), 32'(m_score));
  endtask

  task automatic step(input bit s, input bit a, input bit d1, input logic [9:0] v, input bit d2, input bit c2);
    start = s; abort = a; p1_done = d1; p1_value = v; p2_done = d2; p2_complete = c2;
    @(posedge clk);
    #1;
    model_step();
    check_all();
    if (p2_clear) clears++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 10'd0, 0, 0);
  endtask

  function automatic logic [9:0] rnz();
    return 10'($urandom_range(1, 1023));
  endfunction

  initial begin
    int g, l, sc;
    model_reset();
    #12;
    check_all();
    rstn = 1'b1;
    // Basic win with the documented code value.
    clears = 0;
    step(1, 0, 0, 10'd0, 0, 0);
    step(0, 0, 1, 10'b0101110000, 0, 0);
    idle(5);
    step(0, 0, 0, 10'd0, 0, 1);
    chk("t1_locked", 32'(locked), 32'h170);
    chk("t1_win", 32'(win), 32'd1);
    chk("t1_score", 32'(score), 32'd1);
    chk("t1_clears", 32'(clears), 32'd1);
    // Attempt exhaustion.
    step(1, 0, 0, 10'd0, 0, 0);
    step(0, 0, 1, rnz(), 0, 0);
    clears = 0;
    idle(1);
    chk("t2_att3", 32'(att), 32'd3);
    step(0, 0, 0, 10'd0, 1, 0);
    chk("t2_att2", 32'(att), 32'd2);
    idle(1);
    step(0, 0, 0, 10'd0, 1, 0);
    chk("t2_att1", 32'(att), 32'd1);
    idle(1);
    step(0, 0, 0, 10'd0, 1, 0);
    chk("t2_att0", 32'(att), 32'd0);
    chk("t2_lose", 32'(lose), 32'd1);
    chk("t2_score", 32'(score), 32'd1);
    chk("t2_clears", 32'(clears), 32'd2);
    // Timer expiry, or no expiry without the timer.
    step(1, 0, 0, 10'd0, 0, 0);
    step(0, 0, 1, rnz(), 0, 0);
    g = -1; l = -1;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (p2_en && g < 0) g = i;
      if (lose && l < 0) l = i;
    end
`ifdef ROUND_SEQ_TIMEOUT_EN
    chk("t3_lose_delay", 32'(l - g), 32'd9);
`else
    chk("t3_still_guess", 32'(p2_en), 32'd1);
    chk("t3_no_lose", 32'(lose), 32'd0);
`endif
    step(0, 1, 0, 10'd0, 0, 0);
    // Zero code ignored, then abort mid-guess keeps the score.
    step(1, 0, 0, 10'd0, 0, 0);
    step(0, 0, 1, 10'd0, 0, 0);
    chk("t4_p1_hold", 32'(p1_en), 32'd1);
    step(0, 0, 1, rnz(), 0, 0);
    idle(3);
    sc = int'(score);
    step(0, 1, 0, 10'd0, 1, 1);
    chk("t4_abort_p2en", 32'(p2_en), 32'd0);
    chk("t4_abort_win", 32'(win), 32'd0);
    chk("t4_abort_score", 32'(score), 32'(sc));
    // Complete beats done on the last attempt.
    step(1, 0, 0, 10'd0, 0, 0);
    step(0, 0, 1, rnz(), 0, 0);
    idle(1);
    step(0, 0, 0, 10'd0, 1, 0);
    idle(1);
    step(0, 0, 0, 10'd0, 1, 0);
    idle(1);
    step(0, 0, 0, 10'd0, 1, 1);
    chk("t5_win", 32'(win), 32'd1);
    chk("t5_att", 32'(att), 32'd1);
    // Score saturation.
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 10'd0, 0, 0);
      step(0, 0, 1, rnz(), 0, 0);
      idle(1);
      step(0, 0, 0, 10'd0, 0, 1);
    end
    chk("t6_score_sat", 32'(score), 32'd15);
    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom % 4 == 0, $urandom % 32 == 0, $urandom % 3 == 0,
           ($urandom % 4 == 0) ? 10'd0 : rnz(), $urandom % 4 == 0, $urandom % 8 == 0);
    // Asynchronous reset in the middle of a guess.
    step(0, 1, 0, 10'd0, 0, 0);
    step(1, 0, 0, 10'd0, 0, 0);
    step(0, 0, 1, rnz(), 0, 0);
    idle(2);
    chk("t7_in_guess", 32'(p2_en), 32'd1);
    #3 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rstn = 1'b1;
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Round controller for the two-player morse game. It sequences one round: player1 code entry, code lock, player2 guessing under an attempt budget and cycle timer, then the win/lose verdict. It gates the player1 and player2 datapaths, holds the locked code fed to player2's p1_value, pulses player2's clear, and keeps a running score across rounds.

Parameters:
MAX_ATTEMPTS, 3, guesses allowed per round (1..15)
TIME_LIMIT, 50000000, guess-phase budget in clock cycles (>=1)
TIMER_W, 26, timer width; must hold TIME_LIMIT
SCORE_W, 4, score counter width

Ports:
clock  input  1  system clock, all state on posedge
resetn  input  1  asynchronous active-low reset
start  input  1  begin round from IDLE, WIN or LOSE (level, sampled per cycle)
abort  input  1  return to IDLE from any state
p1_done  input  1  player1 finished entering code
p1_value  input  10  player1's entered code
p2_done  input  1  player2 submits current guess
p2_complete  input  1  player2 complete flag (guess equals code)
p1_en  output  1  player1 entry enabled
p2_en  output  1  player2 guessing enabled
p2_clear  output  1  one-cycle pulse; drives player2 reset (inverted externally)
locked_code  output  10  frozen player1 code fed to player2
attempts_left  output  4  remaining guesses
timer  output  TIMER_W  remaining guess cycles
win  output  1  round won (held)
lose  output  1  round lost (held)
score  output  SCORE_W  rounds won since reset

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0 except attempts_left=MAX_ATTEMPTS; score=0; locked_code=0.
- States: IDLE, P1_ENTRY, LOCK, GUESS, CLEAR, WIN, LOSE. Outputs registered, valid the cycle after state entry.
- abort=1 in any state: next state IDLE; score, locked_code kept; p1_en, p2_en, win, lose cleared. Abort beats every other input.
- IDLE: start -> P1_ENTRY.
- P1_ENTRY: p1_en=1. p1_done with p1_value!=0 -> LOCK, locked_code<=p1_value that cycle. p1_done with p1_value==0 ignored (stay).
- LOCK (1 cycle): p1_en=0, p2_clear=1, attempts_left<=MAX_ATTEMPTS, timer<=TIME_LIMIT -> GUESS.
- GUESS: p2_en=1; timer decrements by 1 per cycle, stops at 0.
  - Priority: p2_complete > p2_done > timer==0.
  - p2_complete -> WIN.
  - p2_done: if attempts_left==1 -> LOSE (attempts_left<=0); else attempts_left-1, -> CLEAR.
  - timer==0 with neither -> LOSE.
- CLEAR (1 cycle): p2_clear=1, p2_en=0, timer holds (not reloaded) -> GUESS.
- WIN: win=1; score+1 on entry only, saturating at 2^SCORE_W-1. LOSE: lose=1. Both hold until start -> P1_ENTRY (win/lose cleared, locked_code kept until next lock).
- start outside IDLE/WIN/LOSE ignored. p2_* ignored outside GUESS; p1_done ignored outside P1_ENTRY.
- Reset mid-round: immediate return to reset values; no partial score update.

Optional Feature:
ROUND_SEQ_TIMEOUT_EN: defined -> timer as above, expiry causes LOSE. Undefined -> no timer register, timer output tied 0, GUESS never exits on time; only complete or attempt exhaustion end the round.

Test Plan:
- Reset, start, p1_done with p1_value=10'b0101110000, p2_complete 5 cycles into GUESS -> locked_code=0x170, win=1, score=1, one p2_clear pulse total.
- MAX_ATTEMPTS=3, three p2_done without complete -> two CLEAR pulses, attempts_left 3->2->1->0, lose=1, score unchanged.
- TIME_LIMIT=8 (macro on), no player2 activity -> lose=1 exactly 9 cycles after LOCK; macro off -> stays GUESS for 100 cycles.
- p2_done and p2_complete same cycle with attempts_left=1 -> WIN, attempts_left stays 1.
- p1_done with p1_value=0 -> stays P1_ENTRY; abort in GUESS -> IDLE next cycle, score retained.
- 16 consecutive wins with SCORE_W=4 -> score saturates at 15; resetn pulse mid-GUESS -> all outputs to reset values asynchronously.
